// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the four-channel digit scan sequencer.
package scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    // Counter width able to hold max(dwell, blank) - 1, never narrower than one bit.
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = (dwell > blank) ? dwell : blank;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control/status bundle between a scan controller and whatever drives its run/mask inputs.
interface digit_scan_ctrl_if;
    import scan_pkg::*;

    logic              run;
    logic [NUM_CH-1:0] ch_mask;
    logic [SEL_W-1:0]  sel;
    logic              en;
    logic              frame_done;

    modport master (
        output run,
        output ch_mask,
        input  sel,
        input  en,
        input  frame_done
    );

    modport slave (
        input  run,
        input  ch_mask,
        output sel,
        output en,
        output frame_done
    );

endinterface

// File: rtl/digit_scan_ctrl_finder.sv
// Combinational search for the next enabled channel, either from index 0 or cyclically after cur.
module next_ch_finder
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              incl,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap,
    output logic              none
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        nxt  = '0;
        none = 1'b1;
        idx  = '0;
        // The cyclic search visits cur last, so a single-channel mask lands back on itself.
        for (int i = 0; i < NUM_CH; i++) begin
            idx = incl ? SEL_W'(i) : SEL_W'(cur + SEL_W'(i + 1));
            if (none && ch_mask[idx]) begin
                nxt  = idx;
                none = 1'b0;
            end
        end
        wrap = !incl && !none && (nxt <= cur);
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed channel sequencer: dwells on each enabled channel, blanking between them.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DWELL = 1000,
    parameter int BLANK = 4
) (
    input  logic              clk,
    input  logic              rst,
    digit_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(DWELL, BLANK);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q, en_d;
    logic             frame_done_q, frame_done_d;

    logic [SEL_W-1:0] nxt_ch;
    logic             nxt_wrap;
    logic             nxt_none;
    logic             search_incl;

    // In IDLE the search restarts from channel 0; elsewhere it continues after sel.
    assign search_incl = (state_q == ST_IDLE);

    next_ch_finder u_finder (
        .ch_mask (bus.ch_mask),
        .cur     (sel_q),
        .incl    (search_incl),
        .nxt     (nxt_ch),
        .wrap    (nxt_wrap),
        .none    (nxt_none)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        en_d         = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.run && !nxt_none) begin
                    sel_d = nxt_ch;
                    cnt_d = '0;
                    if (BLANK == 0) begin
                        state_d = ST_SHOW;
                        en_d    = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
            end

            ST_BLANK: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHOW: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    // The mask is only consulted here, so a mid-dwell change never cuts the dwell short.
                    if (nxt_none) begin
                        state_d = ST_IDLE;
                    end else begin
                        sel_d        = nxt_ch;
                        frame_done_d = nxt_wrap;
                        if (BLANK == 0) begin
                            state_d = ST_SHOW;
                            en_d    = 1'b1;
                        end else begin
                            state_d = ST_BLANK;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    en_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            en_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl with DWELL = 3, BLANK = 1.
module tb_digit_scan_ctrl;
    import scan_pkg::*;

    typedef struct packed {
        logic [7:0] scen;
        logic [1:0] sel;
        logic       en;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_v = 1'b1;
    logic       run_v = 1'b0;
    logic [3:0] mask_v = 4'b0000;
    logic [7:0] scen = 8'd0;

    digit_scan_ctrl_if bus();

    digit_scan_ctrl #(.DWELL(3), .BLANK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic [1:0] s, input logic e, input logic f);
        exp_t x;
        @(negedge clk);
        rst         = rst_v;
        bus.run     = run_v;
        bus.ch_mask = mask_v;
        x.scen = scen;
        x.sel  = s;
        x.en   = e;
        x.fd   = f;
        exp_q.push_back(x);
    endtask

    // One channel period: a blank cycle (carrying any frame_done) then three lit cycles.
    task automatic chan(input logic [1:0] c, input logic f);
        step(c, 1'b0, f);
        repeat (3) step(c, 1'b1, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t m;
        #1;
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            checks++;
            if ({bus.sel, bus.en, bus.frame_done} !== {m.sel, m.en, m.fd}) begin
                errors++;
                $display("FAIL outputs[scenario %0d] t=%0t: sel/en/frame_done got %0d/%0b/%0b expected %0d/%0b/%0b",
                         m.scen, $time, bus.sel, bus.en, bus.frame_done, m.sel, m.en, m.fd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.run     = 1'b0;
        bus.ch_mask = 4'b0000;

        scen = 8'd1; rst_v = 1'b1; run_v = 1'b1; mask_v = 4'b1111;
        repeat (2) step(2'd0, 1'b0, 1'b0);

        scen = 8'd2; rst_v = 1'b0;
        chan(2'd0, 1'b0);
        chan(2'd1, 1'b0);
        chan(2'd2, 1'b0);
        chan(2'd3, 1'b0);
        chan(2'd0, 1'b1);
        chan(2'd1, 1'b0);

        scen = 8'd5;
        step(2'd2, 1'b0, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        run_v = 1'b0;
        step(2'd2, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0);
        run_v = 1'b1;
        chan(2'd0, 1'b0);

        scen = 8'd3; mask_v = 4'b1010;
        chan(2'd1, 1'b0);
        chan(2'd3, 1'b0);
        chan(2'd1, 1'b1);
        chan(2'd3, 1'b0);
        chan(2'd1, 1'b1);

        scen = 8'd4; mask_v = 4'b0100;
        chan(2'd2, 1'b0);
        chan(2'd2, 1'b1);
        chan(2'd2, 1'b1);

        scen = 8'd6; run_v = 1'b0; mask_v = 4'b0000;
        step(2'd2, 1'b0, 1'b0);
        run_v = 1'b1;
        step(2'd2, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0);
        mask_v = 4'b1000;
        step(2'd3, 1'b0, 1'b0);
        step(2'd3, 1'b1, 1'b0);
        mask_v = 4'b0000;
        step(2'd3, 1'b1, 1'b0);
        step(2'd3, 1'b1, 1'b0);
        step(2'd3, 1'b0, 1'b0);
        step(2'd3, 1'b0, 1'b0);

        scen = 8'd7; mask_v = 4'b1111;
        chan(2'd0, 1'b0);
        step(2'd1, 1'b0, 1'b0);
        step(2'd1, 1'b1, 1'b0);
        rst_v = 1'b1;
        step(2'd0, 1'b0, 1'b0);
        rst_v = 1'b0; run_v = 1'b0;
        step(2'd0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
